uart_tx_buffered: RTL and testbench



---
 rtl/uart_tx_buffered.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_buffered
//  Purpose  : Buffered UART transmitter. Bytes written through the store
//             strobe are queued in a 2^FIFO_AW-entry FIFO and serialised on
//             txd, LSB first. A write to a full FIFO is dropped and counted,
//             unless the serialiser pops in the same cycle.
//  Ports    : clk        - system clock
//             reset      - synchronous, active-high reset
//             din[31:0]  - write data, only din[7:0] is transmitted
//             we         - write strobe, one byte per high cycle
//             txd        - serial output, idle high, registered
//             busy       - frame in progress or FIFO non-empty
//             level      - FIFO occupancy, 0..2^FIFO_AW
//             drop_count - bytes lost on a full FIFO, saturating at 0xFFFF
//  Options  : define UART_TX_PARITY_EN for 8E1 framing (default 8N1)
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_AW      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          din,
    input  logic                 we,
    output logic                 txd,
    output logic                 busy,
    output logic [FIFO_AW:0]     level,
    output logic [15:0]          drop_count
);

    localparam int c_depth  = 1 << FIFO_AW;
    localparam int c_baud_w = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0]    c_full      = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state, w_state_n;
    logic [c_baud_w-1:0]   r_baud, w_baud_n;
    logic [2:0]            r_bit_idx, w_bit_idx_n;
    logic [7:0]            r_shift, w_shift_n;
    logic                  r_txd, w_txd_n;
`ifdef UART_TX_PARITY_EN
    logic                  r_parity, w_parity_n;
`endif

    logic [7:0]            r_mem [c_depth];
    logic [FIFO_AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [FIFO_AW:0]      r_level;
    logic [15:0]           r_drop_count;

    logic                  w_pop, w_push, w_drop, w_full, w_baud_last;
    logic [7:0]            w_head;
    logic                  w_unused_din;

    assign w_unused_din = ^din[31:8];
    assign w_full       = (r_level == c_full);
    assign w_head       = r_mem[r_rd_ptr];
    assign w_baud_last  = (r_baud == c_baud_last);

    // A pop frees a slot in the same cycle, so a push to a full FIFO is
    // still accepted then; the old head is read before the slot is reused.
    assign w_push = we && (!w_full || w_pop);
    assign w_drop = we && w_full && !w_pop;

    // ------------------------------------------------------------------
    // Serialiser next-state logic. txd is registered, so its next value is
    // chosen here together with the transition that produces it.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_n   = r_state;
        w_baud_n    = r_baud;
        w_bit_idx_n = r_bit_idx;
        w_shift_n   = r_shift;
        w_txd_n     = r_txd;
`ifdef UART_TX_PARITY_EN
        w_parity_n  = r_parity;
`endif
        w_pop       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_txd_n = 1'b1;
                if (r_level != '0) begin
                    w_pop     = 1'b1;
                    w_shift_n = w_head;
`ifdef UART_TX_PARITY_EN
                    w_parity_n = ^w_head;
`endif
                    w_baud_n  = '0;
                    w_state_n = S_START;
                    w_txd_n   = 1'b0;
                end
            end
            S_START: begin
                if (w_baud_last) begin
                    w_baud_n    = '0;
                    w_bit_idx_n = 3'd0;
                    w_state_n   = S_DATA;
                    w_txd_n     = r_shift[0];
                end else begin
                    w_baud_n = r_baud + 1'b1;
                end
            end
            S_DATA: begin
                if (w_baud_last) begin
                    w_baud_n = '0;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_n = S_PARITY;
                        w_txd_n   = r_parity;
`else
                        w_state_n = S_STOP;
                        w_txd_n   = 1'b1;
`endif
                    end else begin
                        w_bit_idx_n = r_bit_idx + 1'b1;
                        w_shift_n   = r_shift >> 1;
                        w_txd_n     = r_shift[1];
                    end
                end else begin
                    w_baud_n = r_baud + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_baud_last) begin
                    w_baud_n  = '0;
                    w_state_n = S_STOP;
                    w_txd_n   = 1'b1;
                end else begin
                    w_baud_n = r_baud + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_baud_last) begin
                    w_baud_n = '0;
                    // Chain straight into the next start bit when data waits.
                    if (r_level != '0) begin
                        w_pop     = 1'b1;
                        w_shift_n = w_head;
`ifdef UART_TX_PARITY_EN
                        w_parity_n = ^w_head;
`endif
                        w_state_n = S_START;
                        w_txd_n   = 1'b0;
                    end else begin
                        w_state_n = S_IDLE;
                        w_txd_n   = 1'b1;
                    end
                end else begin
                    w_baud_n = r_baud + 1'b1;
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_txd_n   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_txd     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_n;
            r_baud    <= w_baud_n;
            r_bit_idx <= w_bit_idx_n;
            r_shift   <= w_shift_n;
            r_txd     <= w_txd_n;
`ifdef UART_TX_PARITY_EN
            r_parity  <= w_parity_n;
`endif
        end
    end

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_drop_count <= 16'h0000;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_drop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
        end
    end

    assign txd        = r_txd;
    assign busy       = (r_state != S_IDLE) || (r_level != '0);
    assign level      = r_level;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_buffered
//  Purpose  : Self-checking bench for uart_tx_buffered (CLKS_PER_BIT=4,
//             FIFO_AW=2). A queue-based frame model predicts txd, busy,
//             level and drop_count every cycle; directed scenarios add
//             hand-computed frame patterns.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buffered;

    localparam int CPB   = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CYC = NBITS * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] din = 32'h0;
    logic        we = 1'b0;
    logic        txd;
    logic        busy;
    logic [AW:0] level;
    logic [15:0] drop_count;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .we         (we),
        .txd        (txd),
        .busy       (busy),
        .level      (level),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a byte queue plus the frame currently on the wire,
    // described as a bit vector indexed by elapsed cycles / CPB.
    // ------------------------------------------------------------------
    logic [7:0]       mq[$];
    bit               m_active = 1'b0;
    int               m_fcyc = 0;
    logic [NBITS-1:0] m_bits = '1;
    logic [15:0]      m_drops = 16'h0;

    always @(posedge clk) begin : model
        bit         pop;
        logic [7:0] b;
        if (reset) begin
            mq.delete();
            m_active = 1'b0;
            m_fcyc   = 0;
            m_drops  = 16'h0;
        end else begin
            pop = (mq.size() != 0) && (!m_active || m_fcyc == FRAME_CYC - 1);
            if (m_active) begin
                m_fcyc++;
                if (m_fcyc == FRAME_CYC) m_active = 1'b0;
            end
            if (pop) begin
                b = mq.pop_front();
`ifdef UART_TX_PARITY_EN
                m_bits = {1'b1, ^b, b, 1'b0};
`else
                m_bits = {1'b1, b, 1'b0};
`endif
                m_active = 1'b1;
                m_fcyc   = 0;
            end
            if (we) begin
                if (mq.size() < DEPTH) mq.push_back(din[7:0]);
                else if (m_drops != 16'hFFFF) m_drops++;
            end
        end
    end

    always @(negedge clk) begin : compare
        if (chk_en) begin
            chk("model_txd",   {31'b0, txd},  {31'b0, (m_active ? m_bits[m_fcyc / CPB] : 1'b1)});
            chk("model_busy",  {31'b0, busy}, {31'b0, (m_active || mq.size() != 0)});
            chk("model_level", {29'b0, level}, 32'(mq.size()));
            chk("model_drops", {16'b0, drop_count}, {16'b0, m_drops});
        end
    end

    // Push one byte while idle and check the resulting frame against a
    // hand-written bit pattern (bit 0 = start bit), then its exact length.
    task automatic check_frame(input string nm, input logic [31:0] d, input logic [10:0] pat);
        int c;
        din = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
        @(negedge clk);
        chk({nm, "_start"}, {31'b0, txd}, 32'd0);
        c = 0;
        for (int k = 0; k < NBITS; k++) begin
            repeat (4 * k + 2 - c) @(negedge clk);
            c = 4 * k + 2;
            chk({nm, "_bit"}, {31'b0, txd}, {31'b0, pat[k]});
        end
        repeat (FRAME_CYC - 1 - c) @(negedge clk);
        chk({nm, "_busy_last"}, {31'b0, busy}, 32'd1);
        @(negedge clk);
        chk({nm, "_busy_end"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic wait_idle(input string nm, input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_idle_timeout"}, {31'b0, busy}, 32'd0);
    endtask

    logic [10:0] p_a5, p_00, p_3c;
    int          t0, t1;

    initial begin
`ifdef UART_TX_PARITY_EN
        p_a5 = 11'b1_0_1010_0101_0;
        p_00 = 11'b1_0_0000_0000_0;
        p_3c = 11'b1_0_0011_1100_0;
`else
        p_a5 = 11'b0_1_1010_0101_0;
        p_00 = 11'b0_1_0000_0000_0;
        p_3c = 11'b0_1_0011_1100_0;
`endif
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_txd",   {31'b0, txd},  32'd1);
        chk("rst_busy",  {31'b0, busy}, 32'd0);
        chk("rst_level", {29'b0, level}, 32'd0);
        chk("rst_drops", {16'b0, drop_count}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        check_frame("a5", 32'h0000_00A5, p_a5);
        repeat (3) @(negedge clk);
        check_frame("upper", 32'hFFFF_FF00, p_00);
        repeat (3) @(negedge clk);

        // Burst of six writes: 0x01 pops on the second edge, 0x06 is lost.
        for (int i = 0; i < 6; i++) begin
            din = 32'(i + 1); we = 1'b1;
            @(negedge clk);
            if (i == 1) begin
                chk("burst_start", {31'b0, txd}, 32'd0);
                t0 = cyc;
            end
            if (i >= 4) chk("burst_peak", {29'b0, level}, 32'd4);
        end
        we = 1'b0;
        chk("burst_drops", {16'b0, drop_count}, 32'd1);
        wait_idle("burst", 400);
        t1 = cyc;
        chk("burst_len", 32'(t1 - t0), 32'(5 * FRAME_CYC));
        repeat (3) @(negedge clk);

        // Fill the FIFO, then write exactly on the cycle the first frame ends.
        for (int i = 0; i < 5; i++) begin
            din = 32'h10 + 32'(i); we = 1'b1;
            @(negedge clk);
        end
        we = 1'b0;
        repeat (FRAME_CYC - 4) @(negedge clk);
        chk("pop_push_full", {29'b0, level}, 32'd4);
        din = 32'hEE; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
        chk("pop_push_level", {29'b0, level}, 32'd4);
        chk("pop_push_drops", {16'b0, drop_count}, 32'd1);
        wait_idle("pop_push", 400);
        repeat (3) @(negedge clk);

        // Reset during data bit 3 with a byte still queued.
        din = 32'h5A; we = 1'b1;
        @(negedge clk);
        din = 32'h66;
        @(negedge clk);
        we = 1'b0;
        repeat (17) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_txd",   {31'b0, txd},  32'd1);
        chk("midrst_level", {29'b0, level}, 32'd0);
        chk("midrst_busy",  {31'b0, busy}, 32'd0);
        chk("midrst_drops", {16'b0, drop_count}, 32'd0);
        @(negedge clk);
        check_frame("after_rst", 32'h3C, p_3c);

`ifdef UART_TX_PARITY_EN
        repeat (2) @(negedge clk);
        check_frame("par07", 32'h07, 11'b1_1_0000_0111_0);
        repeat (2) @(negedge clk);
        check_frame("par03", 32'h03, 11'b1_0_0000_0011_0);
`endif

        // Randomised traffic alternating light load and heavy bursts.
        for (int i = 0; i < 3000; i++) begin
            din = $urandom;
            we  = ($urandom_range(0, 99) < (((i / 300) % 2 == 1) ? 60 : 4));
            @(negedge clk);
        end
        we = 1'b0;
        wait_idle("random", 2000);
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
